jt7759_feeder: RTL and testbench
================================

// Module: jt7759_feeder
// PURPOSE
// Host-side byte streamer for uPD7759 slave mode (MDN=0). Buffers sample bytes
// written by the host CPU in a small FIFO; on each DRQn request from jt7759_data,
// presents the next byte on din and strobes cs/wrn. Sits between the host bus
// and jt7759's passive interface and replaces CPU polling of DRQn.
// PARAMETERS
// AW     3  log2 of FIFO depth (depth = 2**AW = 8 bytes)
// STRB   4  wrn low time in cen ticks (1..15); cs high spans wrn low plus 1 clk each side
// PORTS
// clk        in   1     system clock
// rst        in   1     synchronous reset, active-high
// cen        in   1     clock enable for the strobe timer (same rate as cen_ctl)
// flush      in   1     clear FIFO, abort any transfer, clear sticky flags
// host_we    in   1     one-clk write pulse from host
// host_din   in   8     byte to enqueue
// host_full  out  1     FIFO full (combinational from level)
// host_lvl   out  AW+1  bytes currently queued, 0..2**AW
// drqn       in   1     data request from jt7759_data, active-low
// cs         out  1     chip select to jt7759
// wrn        out  1     write strobe to jt7759, active-low
// dout       out  8     byte driven to jt7759 din
// underrun   out  1     sticky: DRQn asserted with empty FIFO
// overflow   out  1     sticky: host_we while full (byte dropped)
// BEHAVIOUR
// Reset: cs=0, wrn=1, dout=0, FIFO empty (host_lvl=0), flags=0, state IDLE, drqn_l=1.
// drqn registered into drqn_l each clk; request edge = !drqn && drqn_l.
// FIFO: rd/wr pointers AW bits, wrap modulo 2**AW; level AW+1 bits.
//  - host_we && !full: write at wr ptr, wr++ ; host_we && full: drop, overflow=1.
//  - push and pop same clk: both occur, level unchanged; push on full with same-clk pop accepted.
// FSM (all transitions on clk; only strobe timer gated by cen):
//  IDLE  : request edge & level!=0 -> SETUP. request edge & level==0 -> underrun=1, WAIT.
//  WAIT  : drqn high -> IDLE (request withdrawn). level!=0 & drqn low -> SETUP.
//  SETUP : dout<=fifo[rd], cs<=1, wrn=1, timer<=STRB -> STROBE (1 clk).
//  STROBE: wrn<=0; timer-- on cen; timer==0 -> pop FIFO (rd++), wrn<=1 -> HOLD.
//  HOLD  : cs<=0 next clk; dout held; wait drqn high -> IDLE (one byte per request).
//  Latency request edge -> wrn low: 3 clk (drqn_l, SETUP, STROBE entry).
// dout is stable from SETUP until the next SETUP; never changes while wrn=0.
// A request edge seen outside IDLE is ignored (no queued requests).
// flush (or rst) any state: cs=0, wrn=1 same edge, FIFO emptied, flags cleared,
//  -> IDLE; byte mid-strobe is discarded, not popped-and-sent.
// flush with simultaneous host_we: flush wins, byte dropped, overflow stays 0.
// drqn rising during STROBE: strobe completes to STRB ticks, byte popped.
// cen low throughout: FSM can stall in STROBE indefinitely; FIFO still accepts writes.
// TESTING
// Reset mid-STROBE -> next clk cs=0, wrn=1, host_lvl=0, state IDLE.
// Write 0x11,0x22,0x33; model jt7759_data drqn pulses x3 -> din sequence 11,22,33,
//  each wrn low exactly STRB=4 cen ticks, host_lvl 3->0.
// Write 9 bytes with no requests -> host_full=1 after 8th, overflow=1, 9th dropped,
//  drained order is bytes 1..8.
// drqn falls with empty FIFO -> underrun=1, no strobe; write 0x5A while drqn low
//  -> 0x5A sent within 3 clk of write.
// Push and pop same clk at level 8 -> level stays 8, no overflow, no data lost.
// flush during STROBE with 2 queued -> wrn=1 next edge, host_lvl=0, jt7759 sees no byte.

Source files
------------

// File: rtl/jt7759_feeder_if.sv
// Bus bundle between the host-side streamer and its two neighbours: the host CPU
// write port and the uPD7759 passive data interface (jt7759_data).
interface jt7759_feeder_if #(
    parameter int AW = 3
);
    logic          host_we;
    logic [7:0]    host_din;
    logic          host_full;
    logic [AW:0]   host_lvl;
    logic          drqn;
    logic          cs;
    logic          wrn;
    logic [7:0]    dout;

    // Host CPU plus jt7759 side, i.e. whoever surrounds the feeder
    modport master (
        output host_we, host_din, drqn,
        input  host_full, host_lvl, cs, wrn, dout
    );

    // The feeder itself
    modport slave (
        input  host_we, host_din, drqn,
        output host_full, host_lvl, cs, wrn, dout
    );
endinterface

// File: rtl/jt7759_feeder.sv
// Host-side byte streamer for uPD7759 slave mode. Bytes written by the host are
// queued in a small FIFO; each falling edge of drqn produces exactly one
// cs/wrn strobe carrying the next byte, so the CPU never has to poll drqn.
//
// state  | meaning
// IDLE   | waiting for a drqn falling edge
// WAIT   | request seen with empty FIFO; send as soon as a byte arrives
// SETUP  | latch FIFO head onto dout, raise cs
// STROBE | wrn low for STRB cen ticks, pop on the last tick
// HOLD   | drop cs, wait for drqn to be withdrawn
module jt7759_feeder #(
    parameter int AW   = 3,
    parameter int STRB = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            flush,
    jt7759_feeder_if.slave  bus,
    output logic            underrun,
    output logic            overflow
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t       state;
    logic [7:0]   mem [2**AW];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [AW:0]  lvl;
    logic [3:0]   timer;
    logic         drqn_l;
    logic         cs_r;
    logic         wrn_r;
    logic [7:0]   dout_r;
    logic         req_edge;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full     = lvl[AW];
    assign empty    = (lvl == '0);
    assign req_edge = !bus.drqn && drqn_l;

    // The pop happens on the cen tick that would bring the timer to zero, so wrn
    // stays low for exactly STRB cen ticks counted from the first low cycle.
    assign pop  = !rst && !flush && (state == STROBE) && !wrn_r && cen && (timer == 4'd1);
    // A write on a full FIFO is still taken when a pop frees a slot on the same
    // edge; the popped byte already sits in dout, so overwriting its slot is safe.
    assign push = !rst && !flush && bus.host_we && (!full || pop);

    assign bus.host_full = full;
    assign bus.host_lvl  = lvl;
    assign bus.cs        = cs_r;
    assign bus.wrn       = wrn_r;
    assign bus.dout      = dout_r;

    // FIFO storage, no reset needed: validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= bus.host_din;
    end

    // Control FSM, FIFO pointers, sticky flags and strobe timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cs_r     <= 1'b0;
            wrn_r    <= 1'b1;
            dout_r   <= 8'h00;
            rd       <= '0;
            wr       <= '0;
            lvl      <= '0;
            timer    <= 4'd0;
            underrun <= 1'b0;
            overflow <= 1'b0;
            drqn_l   <= 1'b1;
        end else begin
            drqn_l <= bus.drqn;
            if (flush) begin
                // Any strobe in flight is abandoned; the byte is not popped
                state    <= IDLE;
                cs_r     <= 1'b0;
                wrn_r    <= 1'b1;
                rd       <= '0;
                wr       <= '0;
                lvl      <= '0;
                timer    <= 4'd0;
                underrun <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (push) wr <= wr + 1'b1;
                if (pop)  rd <= rd + 1'b1;
                lvl <= lvl + (AW+1)'(push) - (AW+1)'(pop);
                if (bus.host_we && !push) overflow <= 1'b1;

                case (state)
                    IDLE: begin
                        if (req_edge) begin
                            if (!empty) begin
                                state <= SETUP;
                            end else begin
                                underrun <= 1'b1;
                                state    <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (bus.drqn)    state <= IDLE;
                        else if (!empty) state <= SETUP;
                    end
                    SETUP: begin
                        dout_r <= mem[rd];
                        cs_r   <= 1'b1;
                        wrn_r  <= 1'b1;
                        timer  <= 4'(STRB);
                        state  <= STROBE;
                    end
                    STROBE: begin
                        if (pop) begin
                            wrn_r <= 1'b1;
                            state <= HOLD;
                        end else begin
                            wrn_r <= 1'b0;
                            if (!wrn_r && cen) timer <= timer - 4'd1;
                        end
                    end
                    HOLD: begin
                        cs_r <= 1'b0;
                        if (bus.drqn) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt7759_feeder.sv
// Scoreboard bench for jt7759_feeder: stimulus pushes the bytes the jt7759 side
// should receive; a monitor pops and compares on every completed wrn strobe.
module tb_jt7759_feeder;
    localparam int AW   = 3;
    localparam int STRB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    logic flush = 1'b0;
    logic underrun;
    logic overflow;

    jt7759_feeder_if #(.AW(AW)) bus ();

    jt7759_feeder #(.AW(AW), .STRB(STRB)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .flush    (flush),
        .bus      (bus.slave),
        .underrun (underrun),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        got      = 0;
    int        cen_mode = 0;   // 0: always high, 1: every other clk, 2: held low
    logic      ignore_rise = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_wr(input logic [7:0] b);
        bus.host_we  = 1'b1;
        bus.host_din = b;
        tick(1);
        bus.host_we  = 1'b0;
    endtask

    // One jt7759 data request: drqn low until a byte is strobed, then released
    task automatic do_req(input string nm);
        int n0;
        int k;
        n0 = got;
        k  = 0;
        bus.drqn = 1'b0;
        while (got == n0 && k < 200) begin
            tick(1);
            k++;
        end
        if (got == n0) chk({nm, "_timeout"}, 32'(got - n0), 32'd1);
        bus.drqn = 1'b1;
        tick(2);
    endtask

    // cen generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (cen_mode)
                0:       cen = 1'b1;
                1:       cen = ~cen;
                default: cen = 1'b0;
            endcase
        end
    end

    // Monitor: counts cen ticks while wrn is low and checks each finished strobe
    initial begin
        int         ticks;
        logic       wrn_p;
        logic [7:0] d_low;
        logic [7:0] e;
        ticks = 0;
        wrn_p = 1'b1;
        d_low = 8'h00;
        forever begin
            @(negedge clk);
            if (wrn_p && !bus.wrn) d_low = bus.dout;
            if (!bus.wrn && cen) ticks++;
            if (!wrn_p && bus.wrn) begin
                if (ignore_rise) begin
                    ignore_rise = 1'b0;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {24'h0, bus.dout}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", {24'h0, bus.dout}, {24'h0, e});
                    chk("dout_stable", {24'h0, bus.dout}, {24'h0, d_low});
                    chk("strobe_len", 32'(ticks), 32'(STRB));
                    chk("cs_during_strobe", {31'h0, bus.cs}, 32'd1);
                    got++;
                end
                ticks = 0;
            end
            if (bus.wrn) ticks = 0;
            wrn_p = bus.wrn;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.host_we  = 1'b0;
        bus.host_din = 8'h00;
        bus.drqn     = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_cs",       {31'h0, bus.cs},        32'd0);
        chk("rst_wrn",      {31'h0, bus.wrn},       32'd1);
        chk("rst_dout",     {24'h0, bus.dout},      32'd0);
        chk("rst_lvl",      32'(bus.host_lvl),      32'd0);
        chk("rst_full",     {31'h0, bus.host_full}, 32'd0);
        chk("rst_underrun", {31'h0, underrun},      32'd0);
        chk("rst_overflow", {31'h0, overflow},      32'd0);

        // Three bytes, three requests, cen at half rate
        cen_mode = 1;
        host_wr(8'h11); exp_q.push_back(8'h11);
        host_wr(8'h22); exp_q.push_back(8'h22);
        host_wr(8'h33); exp_q.push_back(8'h33);
        chk("lvl3", 32'(bus.host_lvl), 32'd3);
        do_req("req1"); chk("lvl_after1", 32'(bus.host_lvl), 32'd2);
        do_req("req2"); chk("lvl_after2", 32'(bus.host_lvl), 32'd1);
        do_req("req3"); chk("lvl_after3", 32'(bus.host_lvl), 32'd0);

        // Overflow: 9 writes, 9th dropped
        cen_mode = 0;
        for (int i = 1; i <= 9; i++) begin
            host_wr(8'h80 + 8'(i));
            if (i <= 8) exp_q.push_back(8'h80 + 8'(i));
            if (i == 8) begin
                chk("full_at8", {31'h0, bus.host_full}, 32'd1);
                chk("ovf_at8",  {31'h0, overflow},      32'd0);
            end
        end
        chk("ovf_at9", {31'h0, overflow},  32'd1);
        chk("lvl_at9", 32'(bus.host_lvl),  32'd8);
        for (int i = 0; i < 8; i++) do_req("drain9");
        chk("lvl_drained", 32'(bus.host_lvl), 32'd0);
        chk("ovf_sticky",  {31'h0, overflow}, 32'd1);
        flush = 1'b1; tick(1); flush = 1'b0;
        chk("ovf_cleared", {31'h0, overflow}, 32'd0);

        // Underrun then late byte
        bus.drqn = 1'b0;
        tick(3);
        chk("underrun_set", {31'h0, underrun}, 32'd1);
        chk("underrun_wrn", {31'h0, bus.wrn},  32'd1);
        chk("underrun_cs",  {31'h0, bus.cs},   32'd0);
        exp_q.push_back(8'h5A);
        host_wr(8'h5A);
        k = 0;
        while (bus.wrn && k < 10) begin
            tick(1);
            k++;
        end
        chk("late_latency", 32'(k), 32'd3);
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick(1);
            k++;
        end
        chk("late_sent", 32'(exp_q.size()), 32'd0);
        bus.drqn = 1'b1;
        tick(2);
        chk("underrun_sticky", {31'h0, underrun}, 32'd1);
        flush = 1'b1; tick(1); flush = 1'b0;
        chk("underrun_cleared", {31'h0, underrun}, 32'd0);

        // Push and pop on the same edge at level 8
        for (int i = 0; i < 8; i++) begin
            host_wr(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        chk("pp_full", {31'h0, bus.host_full}, 32'd1);
        bus.drqn = 1'b0;
        tick(6);
        exp_q.push_back(8'hA8);
        host_wr(8'hA8);
        chk("pp_lvl", 32'(bus.host_lvl), 32'd8);
        chk("pp_ovf", {31'h0, overflow},  32'd0);
        chk("pp_wrn_up", {31'h0, bus.wrn}, 32'd1);
        bus.drqn = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) do_req("pp_drain");
        chk("pp_lvl_end", 32'(bus.host_lvl), 32'd0);

        // Flush together with a host write: write dropped, no overflow
        bus.host_we = 1'b1; bus.host_din = 8'hEE; flush = 1'b1;
        tick(1);
        bus.host_we = 1'b0; flush = 1'b0;
        chk("flush_we_lvl", 32'(bus.host_lvl), 32'd0);
        chk("flush_we_ovf", {31'h0, overflow}, 32'd0);

        // Flush mid-strobe with 2 queued, cen held low so the strobe stalls
        cen_mode = 2;
        tick(1);
        host_wr(8'hB1);
        host_wr(8'hB2);
        chk("fl_lvl2", 32'(bus.host_lvl), 32'd2);
        bus.drqn = 1'b0;
        tick(5);
        chk("fl_stalled_wrn", {31'h0, bus.wrn}, 32'd0);
        ignore_rise = 1'b1;
        flush = 1'b1; tick(1); flush = 1'b0;
        chk("fl_wrn", {31'h0, bus.wrn},  32'd1);
        chk("fl_cs",  {31'h0, bus.cs},   32'd0);
        chk("fl_lvl", 32'(bus.host_lvl), 32'd0);
        cen_mode = 0;
        tick(20);
        bus.drqn = 1'b1;
        tick(2);

        // Reset mid-strobe
        cen_mode = 2;
        tick(1);
        host_wr(8'hC1);
        bus.drqn = 1'b0;
        tick(5);
        chk("rs_stalled_wrn", {31'h0, bus.wrn}, 32'd0);
        chk("rs_stalled_cs",  {31'h0, bus.cs},  32'd1);
        ignore_rise = 1'b1;
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("rs_wrn",  {31'h0, bus.wrn},   32'd1);
        chk("rs_cs",   {31'h0, bus.cs},    32'd0);
        chk("rs_lvl",  32'(bus.host_lvl),  32'd0);
        chk("rs_dout", {24'h0, bus.dout},  32'd0);
        cen_mode = 0;
        tick(20);
        bus.drqn = 1'b1;
        tick(4);

        chk("sb_empty",    32'(exp_q.size()), 32'd0);
        chk("bytes_total", 32'(got),          32'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
